// File: rtl/serial_subtractor.sv
// Bit-serial A - B, one bit per clock LSB first, with a registered borrow.
// Operands enter on a valid/ready channel; the result leaves on another.
module serial_subtractor #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_a,
  input  logic [W-1:0] s_b,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_diff,
  output logic         m_borrow,
  output logic         m_ovf,
  output logic         busy
);

  localparam int unsigned CW = (W > 2) ? $clog2(W) : 1;
  localparam int unsigned DW = W - 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_sh_q, a_sh_d;
  logic [W-1:0]    b_sh_q, b_sh_d;
  logic [DW-1:0]   diff_q, diff_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            bw_q, bw_d;
  logic            a_msb_q, a_msb_d;
  logic            b_msb_q, b_msb_d;
  logic            m_valid_q, m_valid_d;
  logic [W-1:0]    m_diff_q, m_diff_d;
  logic            m_borrow_q, m_borrow_d;
  logic            m_ovf_q, m_ovf_d;
  logic            busy_q, busy_d;

  // Full-subtractor slice on the current LSBs.
  logic            a0, b0, d_bit, bw_nxt;
  logic [W-1:0]    diff_full;

  always_comb begin
    a0        = a_sh_q[0];
    b0        = b_sh_q[0];
    d_bit     = a0 ^ b0 ^ bw_q;
    bw_nxt    = (~a0 & b0) | (~(a0 ^ b0) & bw_q);
    diff_full = {d_bit, diff_q};
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    diff_d     = diff_q;
    cnt_d      = cnt_q;
    bw_d       = bw_q;
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    m_valid_d  = m_valid_q;
    m_diff_d   = m_diff_q;
    m_borrow_d = m_borrow_q;
    m_ovf_d    = m_ovf_q;

    unique case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          a_sh_d  = s_a;
          b_sh_d  = s_b;
          a_msb_d = s_a[W-1];
          b_msb_d = s_b[W-1];
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        diff_d = diff_full[W-1:1];
        bw_d   = bw_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(W - 1)) begin
          state_d    = ST_DONE;
          m_valid_d  = 1'b1;
          m_diff_d   = diff_full;
          m_borrow_d = bw_nxt;
          // Signed overflow only when operand signs differ and the result sign left A's.
          m_ovf_d    = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
        end
      end
      ST_DONE: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        m_valid_d = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      diff_q     <= '0;
      cnt_q      <= '0;
      bw_q       <= 1'b0;
      a_msb_q    <= 1'b0;
      b_msb_q    <= 1'b0;
      m_valid_q  <= 1'b0;
      m_diff_q   <= '0;
      m_borrow_q <= 1'b0;
      m_ovf_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      diff_q     <= diff_d;
      cnt_q      <= cnt_d;
      bw_q       <= bw_d;
      a_msb_q    <= a_msb_d;
      b_msb_q    <= b_msb_d;
      m_valid_q  <= m_valid_d;
      m_diff_q   <= m_diff_d;
      m_borrow_q <= m_borrow_d;
      m_ovf_q    <= m_ovf_d;
      busy_q     <= busy_d;
    end
  end

  assign s_ready  = (state_q == ST_IDLE);
  assign m_valid  = m_valid_q;
  assign m_diff   = m_diff_q;
  assign m_borrow = m_borrow_q;
  assign m_ovf    = m_ovf_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (W=8): vector table, corner sequences
// and randomized operands against an integer-arithmetic reference.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rstn;
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_a;
  logic [W-1:0] s_b;
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_diff;
  logic         m_borrow;
  logic         m_ovf;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.W(W)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_a      (s_a),
    .s_b      (s_b),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_diff   (m_diff),
    .m_borrow (m_borrow),
    .m_ovf    (m_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] diff;
    logic       borrow;
    logic       ovf;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                output logic [7:0] d, output logic bo, output logic ov);
    int ia, ib, sa, sb, rs;
    ia = int'(a);
    ib = int'(b);
    d  = 8'((ia - ib + 256) % 256);
    bo = (ia < ib);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    rs = sa - sb;
    ov = (rs > 127) || (rs < -128);
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!s_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("wait_ready", 32'(s_ready), 32'd1);
  endtask

  // Returns edges from the current point until m_valid is seen high.
  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!m_valid && n < 50);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input int stall,
                        input logic [7:0] ed, input logic eb, input logic eo);
    int n;
    wait_ready();
    s_valid = 1'b1;
    s_a     = a;
    s_b     = b;
    m_ready = (stall == 0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_a     = 8'($urandom);
    s_b     = 8'($urandom);
    chk("busy_after_accept", 32'(busy), 32'd1);
    wait_valid(n);
    chk("latency", 32'(n), 32'(W));
    chk("diff", 32'(m_diff), 32'(ed));
    chk("borrow", 32'(m_borrow), 32'(eb));
    chk("ovf", 32'(m_ovf), 32'(eo));
    chk("s_ready_done", 32'(s_ready), 32'd0);
    repeat (stall) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(m_valid), 32'd1);
      chk("hold_diff", 32'(m_diff), 32'(ed));
      chk("hold_borrow", 32'(m_borrow), 32'(eb));
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("valid_drop", 32'(m_valid), 32'd0);
    chk("idle_ready", 32'(s_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("diff_kept", 32'(m_diff), 32'(ed));
  endtask

  initial begin
    logic [7:0] ra, rb, rd;
    logic       rbo, rov;
    int         n;

    tbl[0] = '{a: 8'h5A, b: 8'h23, diff: 8'h37, borrow: 1'b0, ovf: 1'b0};
    tbl[1] = '{a: 8'h00, b: 8'h01, diff: 8'hFF, borrow: 1'b1, ovf: 1'b0};
    tbl[2] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, borrow: 1'b0, ovf: 1'b1};
    tbl[3] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, borrow: 1'b1, ovf: 1'b1};
    tbl[4] = '{a: 8'hFF, b: 8'hFF, diff: 8'h00, borrow: 1'b0, ovf: 1'b0};
    tbl[5] = '{a: 8'h00, b: 8'h80, diff: 8'h80, borrow: 1'b1, ovf: 1'b1};
    tbl[6] = '{a: 8'hC3, b: 8'h3C, diff: 8'h87, borrow: 1'b0, ovf: 1'b0};
    tbl[7] = '{a: 8'h01, b: 8'h7F, diff: 8'h82, borrow: 1'b1, ovf: 1'b0};

    rstn    = 1'b0;
    s_valid = 1'b0;
    s_a     = '0;
    s_b     = '0;
    m_ready = 1'b0;

    // Reset values.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    rstn = 1'b1;
    @(posedge clk); #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_diff", 32'(m_diff), 32'd0);
    chk("rst_m_borrow", 32'(m_borrow), 32'd0);
    chk("rst_m_ovf", 32'(m_ovf), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_s_ready_after", 32'(s_ready), 32'd1);

    // Table vectors.
    for (int i = 0; i < 8; i++)
      run_op(tbl[i].a, tbl[i].b, i % 3, tbl[i].diff, tbl[i].borrow, tbl[i].ovf);

    // Backpressure with a second operand pair held on the input.
    wait_ready();
    s_valid = 1'b1;
    s_a     = 8'h10;
    s_b     = 8'h20;
    m_ready = 1'b0;
    @(posedge clk); #1;
    s_a = 8'h03;
    s_b = 8'h01;
    wait_valid(n);
    chk("bp_latency", 32'(n), 32'(W));
    chk("bp_diff", 32'(m_diff), 32'h0F0);
    chk("bp_borrow", 32'(m_borrow), 32'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", 32'(m_valid), 32'd1);
      chk("bp_hold_diff", 32'(m_diff), 32'h0F0);
      chk("bp_hold_borrow", 32'(m_borrow), 32'd1);
      chk("bp_hold_ready", 32'(s_ready), 32'd0);
    end
    m_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", 32'(m_valid), 32'd0);
    chk("bp_release_idle", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp_second_accept", 32'(s_ready), 32'd0);
    chk("bp_second_busy", 32'(busy), 32'd1);
    s_valid = 1'b0;
    wait_valid(n);
    chk("bp2_latency", 32'(n), 32'(W - 1 + 1));
    chk("bp2_diff", 32'(m_diff), 32'h02);
    chk("bp2_borrow", 32'(m_borrow), 32'd0);
    chk("bp2_ovf", 32'(m_ovf), 32'd0);
    @(posedge clk); #1;
    chk("bp2_done", 32'(m_valid), 32'd0);

    // Reset in the middle of RUN aborts the pending result.
    wait_ready();
    s_valid = 1'b1;
    s_a     = 8'hFF;
    s_b     = 8'h0F;
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("abort_valid", 32'(m_valid), 32'd0);
    chk("abort_diff", 32'(m_diff), 32'd0);
    chk("abort_borrow", 32'(m_borrow), 32'd0);
    chk("abort_ovf", 32'(m_ovf), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(s_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (W + 2) begin
      @(posedge clk); #1;
      chk("abort_no_valid", 32'(m_valid), 32'd0);
    end
    run_op(8'h0F, 8'h0F, 0, 8'h00, 1'b0, 1'b0);

    // Randomized operands and stalls.
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      model(ra, rb, rd, rbo, rov);
      run_op(ra, rb, int'($urandom_range(0, 3)), rd, rbo, rov);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
